// File: rtl/kernel_launcher_if.sv
// Host register bus plus dispatcher launch handshake for kernel_launcher.
// The master side is the host/dispatcher; the slave side is the launcher.
interface kernel_launcher_if;
    logic       host_wr_en;
    logic       host_rd_en;
    logic [2:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic [4:0] thread_count;
    logic       kernel_start;
    logic       disp_reset;
    logic       kernel_complete;
    logic       busy;

    modport master (
        output host_wr_en, host_rd_en, host_addr, host_wdata, kernel_complete,
        input  host_rdata, thread_count, kernel_start, disp_reset, busy
    );

    modport slave (
        input  host_wr_en, host_rd_en, host_addr, host_wdata, kernel_complete,
        output host_rdata, thread_count, kernel_start, disp_reset, busy
    );
endinterface

// File: rtl/kernel_launcher.sv
// Host-facing launch sequencer: register file, launch validation and cycle counter.
// Optional watchdog abort when LAUNCHER_TIMEOUT_EN is defined.
module kernel_launcher #(
    parameter int NUM_CORES        = 4,
    parameter int THREADS_PER_CORE = 4,
    parameter int CYC_W            = 16,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic            clk,
    input  logic            reset,
    kernel_launcher_if.slave bus
);
    localparam int MAX_THREADS = NUM_CORES * THREADS_PER_CORE;

    localparam logic [2:0] ADDR_TC     = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_CYC_LO = 3'd3;
    localparam logic [2:0] ADDR_CYC_HI = 3'd4;

    typedef enum logic [1:0] {IDLE, CLEAR, START, RUN} state_e;

    state_e           state_q, state_d;
    logic [4:0]       tc_q, tc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             timeout_bit;
    logic             abort_pulse;

`ifdef LAUNCHER_TIMEOUT_EN
    localparam int CYC_MAX     = (1 << CYC_W) - 1;
    localparam int TIMEOUT_LIM = (TIMEOUT_CYCLES > CYC_MAX) ? CYC_MAX : TIMEOUT_CYCLES;
    logic timeout_q, timeout_d;
    logic abort_q, abort_d;
    assign timeout_bit = timeout_q;
    assign abort_pulse = abort_q;
`else
    assign timeout_bit = 1'b0;
    assign abort_pulse = 1'b0;
`endif

    logic             busy;
    logic             wr_tc, wr_ctrl, launch_req, launch_ok, tc_valid;
    logic [CYC_W-1:0] cyc_inc;
    logic [7:0]       cyc_hi;

    assign busy     = (state_q != IDLE);
    assign wr_tc    = bus.host_wr_en && (bus.host_addr == ADDR_TC);
    assign wr_ctrl  = bus.host_wr_en && (bus.host_addr == ADDR_CTRL);
    assign tc_valid = (tc_q != 5'd0) && (32'(tc_q) <= MAX_THREADS);
    assign launch_req = wr_ctrl && bus.host_wdata[0];
    assign launch_ok  = launch_req && (state_q == IDLE) && tc_valid;
    // Saturating increment: the runtime pins at all-ones instead of wrapping.
    assign cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

    // NOTE: every target gets its default first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        done_d  = done_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        cyc_hi  = '0;
`ifdef LAUNCHER_TIMEOUT_EN
        timeout_d = timeout_q;
        abort_d   = 1'b0;
`endif

        // Host clears come first so that any set later in this block wins.
        if (wr_ctrl && bus.host_wdata[1]) done_d = 1'b0;
        if (wr_ctrl && bus.host_wdata[2]) begin
            err_d = 1'b0;
`ifdef LAUNCHER_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (launch_ok) begin
                    state_d = CLEAR;
`ifdef LAUNCHER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            CLEAR: begin
                cyc_d   = '0;
                done_d  = 1'b0;
                state_d = START;
            end
            START: begin
                cyc_d   = cyc_inc;
                state_d = RUN;
            end
            RUN: begin
                if (bus.kernel_complete) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef LAUNCHER_TIMEOUT_EN
                end else if (32'(cyc_q) >= TIMEOUT_LIM) begin
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    done_d    = 1'b0;
                    state_d   = IDLE;
`endif
                end else begin
                    cyc_d = cyc_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch_req && !launch_ok) err_d = 1'b1;
        if (wr_tc) begin
            if (busy) err_d = 1'b1;
            else      tc_d  = bus.host_wdata[4:0];
        end

        cyc_hi[CYC_W-9:0] = cyc_q[CYC_W-1:8];
        if (bus.host_rd_en) begin
            unique case (bus.host_addr)
                ADDR_TC:     rdata_d = {3'b000, tc_q};
                ADDR_STATUS: rdata_d = {4'b0000, timeout_bit, err_q, done_q, busy};
                ADDR_CYC_LO: rdata_d = cyc_q[7:0];
                ADDR_CYC_HI: rdata_d = cyc_hi;
                default:     rdata_d = 8'h00;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            rdata_q <= '0;
`ifdef LAUNCHER_TIMEOUT_EN
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
`ifdef LAUNCHER_TIMEOUT_EN
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
`endif
        end
    end

    assign bus.host_rdata   = rdata_q;
    assign bus.thread_count = tc_q;
    assign bus.kernel_start = (state_q == START);
    assign bus.disp_reset   = (state_q == CLEAR) || abort_pulse;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_kernel_launcher.sv
// Scoreboard bench for kernel_launcher: reads push expectations, a monitor pops them.
// With LAUNCHER_TIMEOUT_EN defined the watchdog scenario also runs.
module tb_kernel_launcher;
    logic clk = 1'b0;
    logic reset = 1'b1;

    kernel_launcher_if bus ();

    kernel_launcher #(
        .NUM_CORES(4), .THREADS_PER_CORE(4), .CYC_W(9), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ks_cnt = 0;
    logic rd_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        rd_seen <= bus.host_rd_en && !reset;
        if (bus.kernel_start && !reset) ks_cnt <= ks_cnt + 1;
    end

    // Monitor: each read response is compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_read", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, {24'd0, bus.host_rdata}, {24'd0, e.val});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        bus.host_wr_en = 1'b1;
        bus.host_addr  = addr;
        bus.host_wdata = data;
        @(negedge clk);
        bus.host_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [7:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        bus.host_rd_en = 1'b1;
        bus.host_addr  = addr;
        @(negedge clk);
        bus.host_rd_en = 1'b0;
    endtask

    initial begin
        bus.host_wr_en      = 1'b0;
        bus.host_rd_en      = 1'b0;
        bus.host_addr       = 3'd0;
        bus.host_wdata      = 8'd0;
        bus.kernel_complete = 1'b0;
        tick(3);
        reset = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_kstart", {31'd0, bus.kernel_start}, 32'd0);
        check("rst_dreset", {31'd0, bus.disp_reset}, 32'd0);
        check("rst_tc", {27'd0, bus.thread_count}, 32'd0);
        for (int a = 0; a < 6; a++) rd(3'(a), 8'h00, $sformatf("rst_rd%0d", a));

        // Normal launch: 20 RUN cycles with complete low -> 1 (START) + 20 = 21
        wr(3'd0, 8'd10);
        rd(3'd0, 8'd10, "tc_readback");
        check("tc_out", {27'd0, bus.thread_count}, 32'd10);
        wr(3'd1, 8'h01);
        check("l1_clear_dreset", {31'd0, bus.disp_reset}, 32'd1);
        check("l1_clear_kstart", {31'd0, bus.kernel_start}, 32'd0);
        check("l1_clear_busy", {31'd0, bus.busy}, 32'd1);
        tick(1);
        check("l1_start_kstart", {31'd0, bus.kernel_start}, 32'd1);
        check("l1_start_dreset", {31'd0, bus.disp_reset}, 32'd0);
        tick(1);
        check("l1_run_kstart", {31'd0, bus.kernel_start}, 32'd0);
        check("l1_run_busy", {31'd0, bus.busy}, 32'd1);
        tick(20);
        bus.kernel_complete = 1'b1;
        tick(1);
        bus.kernel_complete = 1'b0;
        check("l1_done_busy", {31'd0, bus.busy}, 32'd0);
        rd(3'd2, 8'h02, "l1_status");
        rd(3'd3, 8'd21, "l1_cyc_lo");
        rd(3'd4, 8'd0, "l1_cyc_hi");
        check("l1_kstart_count", ks_cnt, 32'd1);

        // Invalid thread counts 0 and 17 (MAX=16)
        wr(3'd1, 8'h02);
        wr(3'd0, 8'd0);
        wr(3'd1, 8'h01);
        tick(2);
        check("tc0_busy", {31'd0, bus.busy}, 32'd0);
        wr(3'd0, 8'd17);
        wr(3'd1, 8'h01);
        tick(2);
        check("tc17_kstart_count", ks_cnt, 32'd1);
        rd(3'd0, 8'd17, "tc17_readback");
        rd(3'd2, 8'h04, "bad_tc_status");
        wr(3'd1, 8'h04);
        rd(3'd2, 8'h00, "err_cleared");

        // Launch and thread-count write while running
        wr(3'd0, 8'd5);
        wr(3'd1, 8'h01);
        tick(2);
        wr(3'd1, 8'h01);
        wr(3'd0, 8'd3);
        check("busy_tc_unchanged", {27'd0, bus.thread_count}, 32'd5);
        rd(3'd2, 8'h05, "busy_err_status");
        check("busy_kstart_count", ks_cnt, 32'd2);
        bus.kernel_complete = 1'b1;
        tick(1);
        rd(3'd2, 8'h06, "busy_done_status");

        // Stale complete held high: launch + clear-done together
        wr(3'd1, 8'h04);
        wr(3'd1, 8'h03);
        check("stale_clear_busy", {31'd0, bus.busy}, 32'd1);
        tick(1);
        check("stale_start_kstart", {31'd0, bus.kernel_start}, 32'd1);
        check("stale_start_busy", {31'd0, bus.busy}, 32'd1);
        tick(1);
        check("stale_run_busy", {31'd0, bus.busy}, 32'd1);
        tick(1);
        check("stale_done_busy", {31'd0, bus.busy}, 32'd0);
        bus.kernel_complete = 1'b0;
        rd(3'd2, 8'h02, "stale_status");
        rd(3'd3, 8'd1, "stale_cyc_lo");

        // Boundary thread count 16; launch also clears done and err
        wr(3'd0, 8'd16);
        wr(3'd1, 8'h07);
        tick(5);
        bus.kernel_complete = 1'b1;
        tick(1);
        bus.kernel_complete = 1'b0;
        rd(3'd2, 8'h02, "tc16_status");
        rd(3'd3, 8'd4, "tc16_cyc_lo");
        check("tc16_kstart_count", ks_cnt, 32'd4);

        // Error set beats error clear in the same write
        wr(3'd0, 8'd0);
        wr(3'd1, 8'h05);
        rd(3'd2, 8'h06, "set_wins_status");
        wr(3'd1, 8'h06);
        rd(3'd2, 8'h00, "all_cleared");

`ifndef LAUNCHER_TIMEOUT_EN
        // Saturation of the 9-bit counter at 511
        wr(3'd0, 8'd1);
        wr(3'd1, 8'h01);
        tick(2 + 520);
        bus.kernel_complete = 1'b1;
        tick(1);
        bus.kernel_complete = 1'b0;
        rd(3'd3, 8'hFF, "sat_cyc_lo");
        rd(3'd4, 8'h01, "sat_cyc_hi");
`endif

        // Asynchronous reset mid-RUN
        wr(3'd0, 8'd9);
        rd(3'd0, 8'd9, "pre_rst_tc");
        wr(3'd1, 8'h01);
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_tc", {27'd0, bus.thread_count}, 32'd0);
        check("arst_rdata", {24'd0, bus.host_rdata}, 32'd0);
        check("arst_kstart", {31'd0, bus.kernel_start}, 32'd0);
        check("arst_dreset", {31'd0, bus.disp_reset}, 32'd0);
        tick(2);
        reset = 1'b0;
        rd(3'd2, 8'h00, "post_rst_status");
        rd(3'd3, 8'h00, "post_rst_cyc_lo");

`ifdef LAUNCHER_TIMEOUT_EN
        // Watchdog: abort once the count reaches 50 with complete low
        begin
            int waited;
            waited = 0;
            wr(3'd0, 8'd1);
            wr(3'd1, 8'h01);
            while (bus.busy && waited < 100) begin
                tick(1);
                waited++;
            end
            check("to_within_bound", {31'd0, bus.busy}, 32'd0);
            check("to_abort_dreset", {31'd0, bus.disp_reset}, 32'd1);
            tick(1);
            check("to_dreset_one_cycle", {31'd0, bus.disp_reset}, 32'd0);
            rd(3'd2, 8'h0C, "to_status");
            rd(3'd3, 8'd50, "to_cyc_lo");
            wr(3'd1, 8'h04);
            rd(3'd2, 8'h00, "to_cleared");
        end
`endif

        tick(2);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
